hit_fifo_avs_reader: RTL and testbench



---
 rtl/hit_fifo_avs_reader.sv | 128 ++++++++++++
 tb/tb_hit_fifo_avs_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hit_fifo_avs_reader.sv
// Hit-word FIFO fed by a valid/ready stream and drained by the HPS through an
// Avalon-MM slave, with status and control registers, sticky error flags, and a level IRQ.
module hit_fifo_avs_reader #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hit_valid,
  input  logic [31:0] hit_data,
  output logic        hit_ready,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        irq
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = LW - 1;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_CLEAR   = 2'd3
  } reg_addr_e;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [10:0]   level_ext;
  logic          enable, irq_en;
  logic [10:0]   threshold;
  logic          overflow, underflow;
  logic [7:0]    drop_cnt;

  reg_addr_e     addr;
  logic          full, empty;
  logic          push, pop, drop, read_empty;
  logic          ctrl_wr, clr_wr, flush, clr_ovf, clr_udf;
  logic [31:0]   rd_mux;
  logic          unused_wdata;

  assign addr      = reg_addr_e'(avs_address);
  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign level_ext = 11'(level);
  assign hit_ready = enable & ~full;

  assign push       = hit_valid & hit_ready;
  assign drop       = hit_valid & enable & full;
  assign pop        = avs_read & (addr == REG_DATA) & ~empty;
  assign read_empty = avs_read & (addr == REG_DATA) & empty;

  assign ctrl_wr = avs_write & (addr == REG_CONTROL);
  assign clr_wr  = avs_write & (addr == REG_CLEAR);
  assign flush   = clr_wr & avs_writedata[0];
  assign clr_ovf = clr_wr & avs_writedata[1];
  assign clr_udf = clr_wr & avs_writedata[2];

  assign unused_wdata = ^{avs_writedata[31:27], avs_writedata[15:3]};

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_DATA:    rd_mux = empty ? '0 : mem[rd_ptr];
      REG_STATUS:  rd_mux = {drop_cnt, 4'b0, underflow, overflow, full, empty, 5'b0, level_ext};
      REG_CONTROL: rd_mux = {5'b0, threshold, 14'b0, irq_en, enable};
      default:     rd_mux = '0;
    endcase
  end

  // NOTE: storage has no reset; contents are only observable through level, which does.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= hit_data;
  end

  // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      enable       <= 1'b0;
      irq_en       <= 1'b0;
      threshold    <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      drop_cnt     <= '0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        level <= level + LW'(push) - LW'(pop);
      end

      // Flush and clear both take priority over a drop recorded in the same cycle.
      if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop && !flush) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end

      if (clr_udf)         underflow <= 1'b0;
      else if (read_empty) underflow <= 1'b1;

      if (ctrl_wr) begin
        enable    <= avs_writedata[0];
        irq_en    <= avs_writedata[1];
        threshold <= avs_writedata[26:16];
      end

      if (avs_read) avs_readdata <= rd_mux;

      irq <= irq_en & (((threshold != '0) & (level_ext >= threshold)) | overflow);
    end
  end

endmodule

// File: tb/tb_hit_fifo_avs_reader.sv
// Directed bench for hit_fifo_avs_reader: a vector table for single-cycle behaviour,
// then hand-written sequences for overflow, saturation, pointer wrap and reset.
module tb_hit_fifo_avs_reader;

  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CONTROL = 2'd2, A_CLEAR = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        hit_valid;
  logic [31:0] hit_data;
  logic        hit_ready;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  hit_fifo_avs_reader #(.DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .hit_valid     (hit_valid),
    .hit_data      (hit_data),
    .hit_ready     (hit_ready),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        hv;
    logic [31:0] hd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_ready;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic rd, input logic wr, input logic [1:0] addr,
                     input logic [31:0] wdata, input logic hv, input logic [31:0] hd,
                     input logic chk_rd, input logic [31:0] exp_rd,
                     input logic exp_ready, input logic exp_irq);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.hv = hv; v.hd = hd; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.exp_ready = exp_ready; v.exp_irq = exp_irq;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hit_valid = 1'b0; hit_data = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_address = '0; avs_writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    avs_read = 1'b1; avs_address = a;
    step();
    avs_read = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    step();
    avs_write = 1'b0; avs_writedata = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    //              name            rd wr addr       wdata         hv hd     chk rd            rdy irq
    add("ctrl_en",     0, 1, A_CONTROL, 32'h0000_0001, 0, 32'h0,  0, 32'h0,          1, 0);
    add("push_a0",     0, 0, A_DATA,    32'h0,         1, 32'hA0, 0, 32'h0,          1, 0);
    add("push_a1",     0, 0, A_DATA,    32'h0,         1, 32'hA1, 0, 32'h0,          1, 0);
    add("push_a2",     0, 0, A_DATA,    32'h0,         1, 32'hA2, 0, 32'h0,          1, 0);
    add("push_a3",     0, 0, A_DATA,    32'h0,         1, 32'hA3, 0, 32'h0,          1, 0);
    add("pop_a0",      1, 0, A_DATA,    32'h0,         0, 32'h0,  1, 32'hA0,         1, 0);
    add("pop_a1",      1, 0, A_DATA,    32'h0,         0, 32'h0,  1, 32'hA1,         1, 0);
    add("pop_a2",      1, 0, A_DATA,    32'h0,         0, 32'h0,  1, 32'hA2,         1, 0);
    add("pop_a3",      1, 0, A_DATA,    32'h0,         0, 32'h0,  1, 32'hA3,         1, 0);
    add("stat_empty",  1, 0, A_STATUS,  32'h0,         0, 32'h0,  1, 32'h0001_0000,  1, 0);
    add("pop_empty",   1, 0, A_DATA,    32'h0,         0, 32'h0,  1, 32'h0,          1, 0);
    add("stat_udf",    1, 0, A_STATUS,  32'h0,         0, 32'h0,  1, 32'h0009_0000,  1, 0);
    add("clr_udf",     0, 1, A_CLEAR,   32'h0000_0004, 0, 32'h0,  0, 32'h0,          1, 0);
    add("stat_noudf",  1, 0, A_STATUS,  32'h0,         0, 32'h0,  1, 32'h0001_0000,  1, 0);
    add("ctrl_thr4",   0, 1, A_CONTROL, 32'h0004_0003, 0, 32'h0,  0, 32'h0,          1, 0);
    add("push_b0",     0, 0, A_DATA,    32'h0,         1, 32'hB0, 0, 32'h0,          1, 0);
    add("push_b1",     0, 0, A_DATA,    32'h0,         1, 32'hB1, 0, 32'h0,          1, 0);
    add("push_b2",     0, 0, A_DATA,    32'h0,         1, 32'hB2, 0, 32'h0,          1, 0);
    add("push_b3",     0, 0, A_DATA,    32'h0,         1, 32'hB3, 0, 32'h0,          1, 0);
    add("irq_rise",    0, 0, A_DATA,    32'h0,         0, 32'h0,  0, 32'h0,          1, 1);
    add("pop_b0",      1, 0, A_DATA,    32'h0,         0, 32'h0,  1, 32'hB0,         1, 1);
    add("stat_lvl3",   1, 0, A_STATUS,  32'h0,         0, 32'h0,  1, 32'h0000_0003,  1, 0);
    add("push_b4",     0, 0, A_DATA,    32'h0,         1, 32'hB4, 0, 32'h0,          1, 0);
    add("push_b5",     0, 0, A_DATA,    32'h0,         1, 32'hB5, 0, 32'h0,          1, 1);
    add("push_pop",    1, 0, A_DATA,    32'h0,         1, 32'hB6, 1, 32'hB1,         1, 1);
    add("stat_lvl5",   1, 0, A_STATUS,  32'h0,         0, 32'h0,  1, 32'h0000_0005,  1, 1);
    add("flush_push",  0, 1, A_CLEAR,   32'h0000_0001, 1, 32'hC0, 0, 32'h0,          1, 1);
    add("stat_flush",  1, 0, A_STATUS,  32'h0,         0, 32'h0,  1, 32'h0001_0000,  1, 0);
    add("flush_gone",  1, 0, A_DATA,    32'h0,         0, 32'h0,  1, 32'h0,          1, 0);
    add("clr_udf2",    0, 1, A_CLEAR,   32'h0000_0004, 0, 32'h0,  0, 32'h0,          1, 0);
    add("wr_status",   0, 1, A_STATUS,  32'hFFFF_FFFF, 0, 32'h0,  0, 32'h0,          1, 0);
    add("stat_clean",  1, 0, A_STATUS,  32'h0,         0, 32'h0,  1, 32'h0001_0000,  1, 0);
    add("ctrl_rb",     1, 0, A_CONTROL, 32'h0,         0, 32'h0,  1, 32'h0004_0003,  1, 0);
    add("clear_rb",    1, 0, A_CLEAR,   32'h0,         0, 32'h0,  1, 32'h0,          1, 0);

    step();
    check("rst_ready", 32'(hit_ready), 32'h0);
    check("rst_rdata", avs_readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      avs_read = vecs[i].rd; avs_write = vecs[i].wr; avs_address = vecs[i].addr;
      avs_writedata = vecs[i].wdata; hit_valid = vecs[i].hv; hit_data = vecs[i].hd;
      step();
      if (vecs[i].chk_rd) check({vecs[i].name, "_rd"}, avs_readdata, vecs[i].exp_rd);
      check({vecs[i].name, "_ready"}, 32'(hit_ready), 32'(vecs[i].exp_ready));
      check({vecs[i].name, "_irq"}, 32'(irq), 32'(vecs[i].exp_irq));
    end
    idle_inputs();

    // Fill and overflow: 20 hits into 16 entries.
    bus_write(A_CONTROL, 32'h0000_0003);
    for (int i = 1; i <= 20; i++) begin
      hit_valid = 1'b1; hit_data = 32'h100 + i;
      step();
      check($sformatf("fill_ready_%0d", i), 32'(hit_ready), (i < 16) ? 32'h1 : 32'h0);
    end
    hit_valid = 1'b0;
    bus_read(A_STATUS);
    check("ovf_status", avs_readdata, 32'h0406_0010);
    check("ovf_irq", 32'(irq), 32'h1);
    bus_write(A_CLEAR, 32'h0000_0002);
    bus_read(A_STATUS);
    check("ovf_cleared", avs_readdata, 32'h0002_0010);
    check("ovf_irq_fall", 32'(irq), 32'h0);

    // Drop counter saturation, then clear racing a new drop.
    hit_valid = 1'b1;
    for (int i = 0; i < 260; i++) step();
    hit_valid = 1'b0;
    bus_read(A_STATUS);
    check("drop_sat", avs_readdata, 32'hFF06_0010);
    hit_valid = 1'b1;
    bus_write(A_CLEAR, 32'h0000_0002);
    hit_valid = 1'b0;
    bus_read(A_STATUS);
    check("clr_vs_drop", avs_readdata, 32'h0002_0010);

    // Flush racing an overflow drop: flush wins, no overflow recorded.
    hit_valid = 1'b1;
    bus_write(A_CLEAR, 32'h0000_0001);
    hit_valid = 1'b0;
    bus_read(A_STATUS);
    check("flush_vs_drop", avs_readdata, 32'h0001_0000);

    // Pointer wrap: 40 words, with concurrent push/pop in the middle.
    bus_write(A_CONTROL, 32'h0000_0001);
    for (int k = 0; k < 10; k++) begin
      hit_valid = 1'b1; hit_data = 32'h5000 + k;
      step();
    end
    for (int k = 10; k < 40; k++) begin
      hit_valid = 1'b1; hit_data = 32'h5000 + k;
      avs_read = 1'b1; avs_address = A_DATA;
      step();
      check($sformatf("wrap_%0d", k - 10), avs_readdata, 32'h5000 + (k - 10));
    end
    hit_valid = 1'b0;
    for (int j = 30; j < 40; j++) begin
      avs_read = 1'b1; avs_address = A_DATA;
      step();
      check($sformatf("wrap_%0d", j), avs_readdata, 32'h5000 + j);
    end
    avs_read = 1'b0;
    bus_read(A_STATUS);
    check("wrap_empty", avs_readdata, 32'h0001_0000);

    // Asynchronous reset with seven words queued.
    bus_write(A_CONTROL, 32'h0001_0003);
    for (int k = 0; k < 7; k++) begin
      hit_valid = 1'b1; hit_data = 32'h7000 + k;
      step();
    end
    hit_valid = 1'b0;
    bus_read(A_STATUS);
    check("pre_rst_level", avs_readdata, 32'h0000_0007);
    check("pre_rst_irq", 32'(irq), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_ready", 32'(hit_ready), 32'h0);
    check("async_rdata", avs_readdata, 32'h0);
    check("async_irq", 32'(irq), 32'h0);
    step();
    reset = 1'b0;
    bus_read(A_STATUS);
    check("post_rst_status", avs_readdata, 32'h0001_0000);
    check("post_rst_ready", 32'(hit_ready), 32'h0);
    hit_valid = 1'b1; hit_data = 32'hDEAD;
    step();
    hit_valid = 1'b0;
    bus_read(A_STATUS);
    check("disabled_ignore", avs_readdata, 32'h0001_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
